// File: rtl/vc_demux_rx_pkg.sv
// Shared parameters, per-VC status bundle and flow-control state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vc_demux_rx_pkg;

    localparam int VC_NUM       = 4;
    localparam int WORD_W_DEF   = 4;
    localparam int DEPTH_DEF    = 4;
    localparam int PAUSE_TH_DEF = 3;
    localparam int CONT_TH_DEF  = 1;

    typedef enum logic {
        FC_RUN    = 1'b0,
        FC_PAUSED = 1'b1
    } fc_state_t;

    // Per-VC flags exported by each FIFO slice
    typedef struct packed {
        logic empty;
        logic full;
        logic pause;
        logic stb_pause;
        logic stb_continue;
        logic error;
    } vc_status_t;

endpackage

// File: rtl/vc_rx_fifo.sv
// One VC's word FIFO with occupancy counter, sticky overflow flag and pause/continue FSM.
// Latency: push visible in flags next cycle; head word is combinational from storage.
// Backpressure: none enforced; push into a full FIFO without a same-cycle pop is dropped and flagged.
module vc_rx_fifo
    import vc_demux_rx_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PAUSE_TH = PAUSE_TH_DEF,
    parameter int CONT_TH  = CONT_TH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] push_word,
    input  logic              pop,
    output logic [WORD_W-1:0] head_word,
    output vc_status_t        status
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_nxt;
    logic              is_empty;
    logic              is_full;
    logic              do_push;
    logic              do_pop;
    logic              overflow;
    logic              err_q;
    logic              stb_pause_q;
    logic              stb_cont_q;
    fc_state_t         state;
    fc_state_t         state_nxt;

    assign is_empty  = (occ == '0);
    assign is_full   = (occ == OCC_W'(DEPTH));
    // A pop on a full FIFO frees the slot the same-cycle push will use
    assign do_pop    = pop && !is_empty;
    assign do_push   = push && (!is_full || do_pop);
    assign overflow  = push && is_full && !do_pop;
    assign head_word = mem[rd_ptr];

    // Occupancy after this edge, shared by the counter and the FSM thresholds
    always_comb begin
        occ_nxt = occ;
        if (do_push && !do_pop) begin
            occ_nxt = occ + 1'b1;
        end else if (!do_push && do_pop) begin
            occ_nxt = occ - 1'b1;
        end
    end

    // Word storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // Pointers wrap at DEPTH, occupancy tracks pushes/pops, overflow is sticky
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            err_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            occ <= occ_nxt;
            if (overflow) begin
                err_q <= 1'b1;
            end
        end
    end

    // Flow-control next state: hysteresis between PAUSE_TH and CONT_TH
    always_comb begin
        state_nxt = state;
        case (state)
            FC_RUN:    if (occ_nxt >= OCC_W'(PAUSE_TH)) state_nxt = FC_PAUSED;
            FC_PAUSED: if (occ_nxt <= OCC_W'(CONT_TH))  state_nxt = FC_RUN;
            default:   state_nxt = FC_RUN;
        endcase
    end

    // State register; strobes are registered so they coincide with the pause edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FC_RUN;
            stb_pause_q <= 1'b0;
            stb_cont_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            stb_pause_q <= (state == FC_RUN)    && (state_nxt == FC_PAUSED);
            stb_cont_q  <= (state == FC_PAUSED) && (state_nxt == FC_RUN);
        end
    end

    assign status.empty        = is_empty;
    assign status.full         = is_full;
    assign status.pause        = (state == FC_PAUSED);
    assign status.stb_pause    = stb_pause_q;
    assign status.stb_continue = stb_cont_q;
    assign status.error        = err_q;

endmodule

// File: rtl/vc_demux_rx.sv
// Deserialises an interleaved 4-VC bit stream into per-VC word FIFOs with a shared read port.
// Latency: word pushed on its last bit's edge; rd_data/rd_valid one cycle after rd_req.
// Backpressure: pause/stb_pause/stb_continue advisory per VC; overflow drops the word and sets error.
module vc_demux_rx
    import vc_demux_rx_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PAUSE_TH = PAUSE_TH_DEF,
    parameter int CONT_TH  = CONT_TH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_in,
    input  logic [1:0]        vc_id_in,
    input  logic              valid_in,
    input  logic              rd_req,
    input  logic [1:0]        rd_vc,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [VC_NUM-1:0] empty,
    output logic [VC_NUM-1:0] full,
    output logic [VC_NUM-1:0] pause,
    output logic [VC_NUM-1:0] stb_pause,
    output logic [VC_NUM-1:0] stb_continue,
    output logic [VC_NUM-1:0] error
);

    // WORD_W must be at least 2: only the first WORD_W-1 bits need holding
    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] head [VC_NUM];

    genvar v;
    generate
        for (v = 0; v < VC_NUM; v++) begin : g_vc
            logic [WORD_W-2:0] shreg;
            logic [CNT_W-1:0]  bit_cnt;
            logic [WORD_W-1:0] word;
            logic              sel;
            logic              push;
            logic              pop;
            vc_status_t        status;

            assign sel  = valid_in && !reset && (vc_id_in == 2'(v));
            assign word = {shreg, data_in};
            assign push = sel && (bit_cnt == CNT_W'(WORD_W - 1));
            assign pop  = rd_req && !reset && (rd_vc == 2'(v));

            // Per-VC shift register and bit counter; reset discards any partial word
            always_ff @(posedge clk) begin
                if (reset) begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                end else if (sel) begin
                    shreg   <= word[WORD_W-2:0];
                    bit_cnt <= push ? '0 : bit_cnt + 1'b1;
                end
            end

            vc_rx_fifo #(
                .WORD_W   (WORD_W),
                .DEPTH    (DEPTH),
                .PAUSE_TH (PAUSE_TH),
                .CONT_TH  (CONT_TH)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push      (push),
                .push_word (word),
                .pop       (pop),
                .head_word (head[v]),
                .status    (status)
            );

            assign empty[v]        = status.empty;
            assign full[v]         = status.full;
            assign pause[v]        = status.pause;
            assign stb_pause[v]    = status.stb_pause;
            assign stb_continue[v] = status.stb_continue;
            assign error[v]        = status.error;
        end
    endgenerate

    // Read port: register the selected head word; reads of an empty VC are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req && !empty[rd_vc];
            if (rd_req && !empty[rd_vc]) begin
                rd_data <= head[rd_vc];
            end
        end
    end

endmodule

// File: tb/tb_vc_demux_rx.sv
module tb_vc_demux_rx;

    logic       clk;
    logic       reset;
    logic       data_in;
    logic [1:0] vc_id_in;
    logic       valid_in;
    logic       rd_req;
    logic [1:0] rd_vc;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic [3:0] empty;
    logic [3:0] full;
    logic [3:0] pause;
    logic [3:0] stb_pause;
    logic [3:0] stb_continue;
    logic [3:0] error;

    int n_cmp = 0;
    int n_bad = 0;

    vc_demux_rx dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .vc_id_in     (vc_id_in),
        .valid_in     (valid_in),
        .rd_req       (rd_req),
        .rd_vc        (rd_vc),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .pause        (pause),
        .stb_pause    (stb_pause),
        .stb_continue (stb_continue),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic       dat;
        logic [1:0] vc;
        logic       rd;
        logic [1:0] rvc;
        logic       rv;
        logic [3:0] rdat;
        logic [3:0] emp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic vld, input logic dat, input logic [1:0] vc,
                       input logic rd, input logic [1:0] rvc,
                       input logic rv, input logic [3:0] rdat, input logic [3:0] emp);
        vec_t t;
        t.vld = vld; t.dat = dat; t.vc = vc; t.rd = rd; t.rvc = rvc;
        t.rv = rv; t.rdat = rdat; t.emp = emp;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [1:0] vc, input logic [3:0] w, input logic pop_last);
        for (int i = 3; i >= 0; i--) begin
            valid_in = 1'b1;
            vc_id_in = vc;
            data_in  = w[i];
            rd_req   = pop_last && (i == 0);
            rd_vc    = vc;
            step();
        end
        valid_in = 1'b0;
        rd_req   = 1'b0;
    endtask

    task automatic pop(input logic [1:0] vc);
        rd_req = 1'b1;
        rd_vc  = vc;
        step();
        rd_req = 1'b0;
    endtask

    task automatic chk_idle_state(input string nm);
        chk(nm, 32'({rd_valid, rd_data, empty, full, pause, stb_pause, stb_continue, error}),
                32'({1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}));
    endtask

    initial begin
        reset = 1'b1; data_in = 1'b0; vc_id_in = 2'd0; valid_in = 1'b0;
        rd_req = 1'b0; rd_vc = 2'd0;

        // VC2 word 1011, then read it back, then a read of an empty VC
        add(1, 1, 2, 0, 0, 0, 4'h0, 4'hF);
        add(1, 0, 2, 0, 0, 0, 4'h0, 4'hF);
        add(1, 1, 2, 0, 0, 0, 4'h0, 4'hF);
        add(1, 1, 2, 0, 0, 0, 4'h0, 4'b1011);
        add(0, 0, 0, 1, 2, 1, 4'hB, 4'hF);
        add(0, 0, 0, 0, 0, 0, 4'h0, 4'hF);
        add(0, 0, 0, 1, 0, 0, 4'h0, 4'hF);
        // VC0 1111 interleaved with VC3 0001
        add(1, 1, 0, 0, 0, 0, 4'h0, 4'hF);
        add(1, 0, 3, 0, 0, 0, 4'h0, 4'hF);
        add(1, 1, 0, 0, 0, 0, 4'h0, 4'hF);
        add(1, 0, 3, 0, 0, 0, 4'h0, 4'hF);
        add(1, 1, 0, 0, 0, 0, 4'h0, 4'hF);
        add(1, 0, 3, 0, 0, 0, 4'h0, 4'hF);
        add(1, 1, 0, 0, 0, 0, 4'h0, 4'b1110);
        add(1, 1, 3, 0, 0, 0, 4'h0, 4'b0110);
        add(0, 0, 0, 1, 0, 1, 4'hF, 4'b0111);
        add(0, 0, 0, 1, 3, 1, 4'h1, 4'hF);

        step();
        step();
        chk_idle_state("reset_outputs");
        reset = 1'b0;

        foreach (vq[i]) begin
            valid_in = vq[i].vld;
            data_in  = vq[i].dat;
            vc_id_in = vq[i].vc;
            rd_req   = vq[i].rd;
            rd_vc    = vq[i].rvc;
            step();
            chk($sformatf("vec%0d_flags", i),
                32'({rd_valid, empty, full, pause, stb_pause, stb_continue, error}),
                32'({vq[i].rv, vq[i].emp, 20'h0}));
            if (vq[i].rv) chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vq[i].rdat));
        end
        valid_in = 1'b0;
        rd_req   = 1'b0;

        // Pause/continue hysteresis on VC1
        send_word(2'd1, 4'h5, 1'b0);
        send_word(2'd1, 4'hA, 1'b0);
        chk("vc1_two_words_no_pause", 32'({pause, stb_pause}), 32'h0);
        send_word(2'd1, 4'h3, 1'b0);
        chk("vc1_pause_rise", 32'({pause, stb_pause, stb_continue}), 32'({4'b0010, 4'b0010, 4'h0}));
        step();
        chk("vc1_pause_strobe_single", 32'({pause, stb_pause}), 32'({4'b0010, 4'h0}));
        pop(2'd1);
        chk("vc1_pop1", 32'({rd_valid, rd_data, pause, stb_continue}), 32'({1'b1, 4'h5, 4'b0010, 4'h0}));
        pop(2'd1);
        chk("vc1_pop2_continue", 32'({rd_valid, rd_data, pause, stb_pause, stb_continue}),
                                 32'({1'b1, 4'hA, 4'h0, 4'h0, 4'b0010}));
        step();
        chk("vc1_continue_strobe_single", 32'({pause, stb_continue}), 32'h0);
        pop(2'd1);
        chk("vc1_pop3", 32'({rd_valid, rd_data, empty}), 32'({1'b1, 4'h3, 4'hF}));

        // Overflow on VC0: five words, only four kept
        for (int w = 1; w <= 4; w++) send_word(2'd0, 4'(w), 1'b0);
        chk("vc0_full_no_err", 32'({full, error}), 32'({4'b0001, 4'h0}));
        send_word(2'd0, 4'h5, 1'b0);
        chk("vc0_overflow", 32'({full, error}), 32'({4'b0001, 4'b0001}));
        for (int w = 1; w <= 4; w++) begin
            pop(2'd0);
            chk($sformatf("vc0_drain%0d", w), 32'({rd_valid, rd_data}), 32'({1'b1, 4'(w)}));
        end
        pop(2'd0);
        chk("vc0_drained", 32'({rd_valid, empty, error}), 32'({1'b0, 4'hF, 4'b0001}));

        // Simultaneous push and pop on a full VC1
        for (int w = 6; w <= 9; w++) send_word(2'd1, 4'(w), 1'b0);
        chk("vc1_full", 32'(full), 32'b0010);
        send_word(2'd1, 4'hA, 1'b1);
        chk("vc1_push_pop_full", 32'({rd_valid, rd_data, full, error}), 32'({1'b1, 4'h6, 4'b0010, 4'b0001}));
        for (int w = 7; w <= 10; w++) begin
            pop(2'd1);
            chk($sformatf("vc1_after_pp%0d", w), 32'({rd_valid, rd_data}), 32'({1'b1, 4'(w)}));
        end
        chk("vc1_empty_after_pp", 32'({empty, error}), 32'({4'hF, 4'b0001}));

        // Reset mid-word on VC3 with live inputs, then a fresh word
        send_word(2'd3, 4'hC, 1'b0);
        pop(2'd3);
        valid_in = 1'b1; vc_id_in = 2'd3; data_in = 1'b1; step();
        valid_in = 1'b1; vc_id_in = 2'd3; data_in = 1'b1; step();
        reset = 1'b1; rd_req = 1'b1; rd_vc = 2'd0;
        step();
        chk_idle_state("mid_reset_outputs");
        reset = 1'b0; rd_req = 1'b0; valid_in = 1'b0;
        send_word(2'd3, 4'h6, 1'b0);
        chk("vc3_one_word", 32'(empty), 32'b0111);
        pop(2'd3);
        chk("vc3_fresh_word", 32'({rd_valid, rd_data, empty}), 32'({1'b1, 4'h6, 4'hF}));
        pop(2'd3);
        chk("vc3_no_second_word", 32'(rd_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vc_demux_rx.md
VC_DEMUX_RX -- requirements
Module: vc_demux_rx

Interface
REQ-001 Parameter WORD_W, default 4: bits per word reassembled from the serial stream.
REQ-002 Parameter DEPTH, default 4: words per virtual-channel (VC) FIFO.
REQ-003 Parameter PAUSE_TH, default 3: occupancy at or above which a VC is paused.
REQ-004 Parameter CONT_TH, default 1: occupancy at or below which a paused VC resumes.
REQ-005 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port data_in, input, 1: serial data bit, MSB first.
REQ-008 Port vc_id_in, input, 2: VC that owns data_in this cycle.
REQ-009 Port valid_in, input, 1: data_in and vc_id_in are valid this cycle.
REQ-010 Port rd_req, input, 1: pop request.
REQ-011 Port rd_vc, input, 2: VC to pop.
REQ-012 Port rd_data, output, WORD_W: popped word, registered.
REQ-013 Port rd_valid, output, 1: rd_data valid, one-cycle pulse.
REQ-014 Port empty, output, 4: per-VC FIFO empty.
REQ-015 Port full, output, 4: per-VC FIFO full.
REQ-016 Port pause, output, 4: per-VC paused level.
REQ-017 Port stb_pause, output, 4: per-VC one-cycle pulse on entering paused.
REQ-018 Port stb_continue, output, 4: per-VC one-cycle pulse on leaving paused.
REQ-019 Port error, output, 4: per-VC sticky overflow flag.

Function
REQ-020 Each VC SHALL keep an independent shift register and bit counter, so bits of different VCs may interleave cycle by cycle.
REQ-021 When valid_in=1, data_in SHALL shift into the shift register of VC vc_id_in, and that VC's bit counter SHALL increment mod WORD_W.
REQ-022 On the WORD_W-th bit, the completed word SHALL be pushed into that VC's FIFO on the same edge; empty, full and occupancy SHALL reflect the push from the next cycle.
REQ-023 A push into a full FIFO with no same-cycle pop SHALL drop the word and set error[vc]; error SHALL stay set until reset.
REQ-024 When rd_req=1 and empty[rd_vc]=0, the head word SHALL appear on rd_data with rd_valid=1 one cycle later.
REQ-025 When rd_req=1 and empty[rd_vc]=1, rd_valid SHALL stay 0, no state SHALL change and error SHALL NOT be set.
REQ-026 A simultaneous push and pop on the same VC SHALL both succeed, leave occupancy unchanged and not set error, even when the FIFO is full.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL be held in a counter wide enough for 0..DEPTH.
REQ-028 Each VC SHALL run a two-state flow-control FSM with states RUN and PAUSED; pause[vc]=1 exactly in PAUSED.
REQ-029 The FSM SHALL go RUN->PAUSED when next occupancy >= PAUSE_TH, and stb_pause[vc] SHALL pulse in the same cycle pause rises.
REQ-030 The FSM SHALL go PAUSED->RUN when next occupancy <= CONT_TH, and stb_continue[vc] SHALL pulse in the same cycle pause falls.
REQ-031 stb_pause and stb_continue SHALL never be asserted together for one VC.

Reset
REQ-032 While reset=1, all FIFOs, bit counters, shift registers and error flags SHALL clear, and any partial word SHALL be discarded.
REQ-033 While reset=1, all FSMs SHALL go to RUN.
REQ-034 Reset output values: empty=4'b1111; full, pause, stb_pause, stb_continue and error = 0; rd_valid=0; rd_data=0.
REQ-035 Inputs SHALL be ignored in any cycle with reset=1.

Structure
REQ-036 A shared package SHALL hold WORD_W, DEPTH, PAUSE_TH, CONT_TH defaults, the VC count (4), and the RUN/PAUSED state encoding.
REQ-037 A sub-module vc_rx_fifo SHALL hold one VC's FIFO, occupancy counter and flow-control FSM; it SHALL be instantiated four times.
REQ-038 Deserialisation and the read-port mux SHALL live in the top level.

Verification
REQ-039 Send 4 bits 1,0,1,1 on VC2, then rd_req with rd_vc=2 -> rd_data=4'b1011, rd_valid=1 one cycle after rd_req, and empty[2]=1 afterwards.
REQ-040 Interleave VC0 bits 1,1,1,1 with VC3 bits 0,0,0,1 alternately -> FIFO0 holds 4'hF and FIFO3 holds 4'h1, with no cross-contamination.
REQ-041 Push 3 words into VC1 -> stb_pause[1] pulses once and pause[1]=1; pop 2 words -> stb_continue[1] pulses at occupancy 1.
REQ-042 Push 5 words into VC0 with no reads -> full[0]=1, error[0]=1, and pops return only the first 4 words.
REQ-043 With VC1 full, push and pop VC1 in the same cycle -> occupancy stays 4 and error[1]=0.
REQ-044 Assert reset after 2 bits of a VC3 word, then send 4 fresh bits -> exactly one word is present, equal to the fresh bits.
